// File: rtl/icache_if.sv
// rtl/icache_if.sv - fetch-side and memory-side signal bundle for the instruction cache
interface icache_if;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;

  // master: datapath fetch port plus memory controller model
  modport master (
    output imemREN, imemaddr, iwait, iload,
    input  ihit, imemload, iREN, iaddr
  );

  modport slave (
    input  imemREN, imemaddr, iwait, iload,
    output ihit, imemload, iREN, iaddr
  );
endinterface

// File: rtl/icache.sv
// rtl/icache.sv - two-way set-associative read-only instruction cache with LRU replacement
module icache #(
  parameter int INDEX_W = 3
) (
  input  logic     CLK,
  input  logic     nRST,
  icache_if.slave  bus
);
  localparam int SETS  = 1 << INDEX_W;
  localparam int TAG_W = 30 - INDEX_W;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] FILL = 1'b1;

  logic [0:0]       state;
  logic [31:0]      miss_addr;

  logic             valid0 [SETS];
  logic             valid1 [SETS];
  logic [TAG_W-1:0] tag0   [SETS];
  logic [TAG_W-1:0] tag1   [SETS];
  logic [31:0]      data0  [SETS];
  logic [31:0]      data1  [SETS];
  logic             lru    [SETS];

  logic [TAG_W-1:0]   cur_tag;
  logic [INDEX_W-1:0] cur_idx;
  logic [TAG_W-1:0]   miss_tag;
  logic [INDEX_W-1:0] miss_idx;
  logic               hit0;
  logic               hit1;
  logic               lookup_hit;
  logic               victim;

  assign cur_tag  = bus.imemaddr[31:2+INDEX_W];
  assign cur_idx  = bus.imemaddr[1+INDEX_W:2];
  assign miss_tag = miss_addr[31:2+INDEX_W];
  assign miss_idx = miss_addr[1+INDEX_W:2];

  assign hit0       = valid0[cur_idx] && (tag0[cur_idx] == cur_tag);
  assign hit1       = valid1[cur_idx] && (tag1[cur_idx] == cur_tag);
  assign lookup_hit = (state == IDLE) && bus.imemREN && (hit0 || hit1);

  // Empty frames are consumed before LRU is consulted, way0 first.
  assign victim = !valid0[miss_idx] ? 1'b0 :
                  !valid1[miss_idx] ? 1'b1 : lru[miss_idx];

  assign bus.ihit     = lookup_hit;
  assign bus.imemload = !lookup_hit ? 32'h0 : (hit0 ? data0[cur_idx] : data1[cur_idx]);
  assign bus.iREN     = (state == FILL);
  assign bus.iaddr    = miss_addr;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= IDLE;
      miss_addr <= 32'h0;
      for (int i = 0; i < SETS; i++) begin
        valid0[i] <= 1'b0;
        valid1[i] <= 1'b0;
        tag0[i]   <= '0;
        tag1[i]   <= '0;
        data0[i]  <= 32'h0;
        data1[i]  <= 32'h0;
        lru[i]    <= 1'b0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (bus.imemREN) begin
            if (hit0 || hit1) begin
              lru[cur_idx] <= hit0;
            end else begin
              miss_addr <= {bus.imemaddr[31:2], 2'b00};
              state     <= FILL;
            end
          end
        end
        FILL: begin
          if (!bus.iwait) begin
            if (victim) begin
              valid1[miss_idx] <= 1'b1;
              tag1[miss_idx]   <= miss_tag;
              data1[miss_idx]  <= bus.iload;
            end else begin
              valid0[miss_idx] <= 1'b1;
              tag0[miss_idx]   <= miss_tag;
              data0[miss_idx]  <= bus.iload;
            end
            lru[miss_idx] <= ~victim;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_icache.sv
// tb/tb_icache.sv - directed table-driven bench for the instruction cache
module tb_icache;
  logic CLK = 1'b0;
  logic nRST = 1'b0;
  int   checks = 0;
  int   errors = 0;

  icache_if bus ();
  icache #(.INDEX_W(3)) dut (.CLK(CLK), .nRST(nRST), .bus(bus));

  always #5 CLK = ~CLK;

  typedef struct {
    logic        do_rst;
    logic        ren;
    logic [31:0] addr;
    logic        wt;
    logic [31:0] load;
    logic        eh;
    logic [31:0] ed;
    logic        er;
    logic [31:0] ea;
  } vec_t;

  vec_t vq[$];

  task automatic push(input logic r, input logic ren, input logic [31:0] addr,
                      input logic wt, input logic [31:0] load, input logic eh,
                      input logic [31:0] ed, input logic er, input logic [31:0] ea);
    vec_t v;
    v.do_rst = r; v.ren = ren; v.addr = addr; v.wt = wt; v.load = load;
    v.eh = eh; v.ed = ed; v.er = er; v.ea = ea;
    vq.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tagname, input logic eh, input logic [31:0] ed,
                            input logic er, input logic [31:0] ea);
    check({tagname, ".ihit"},     {31'h0, bus.ihit}, {31'h0, eh});
    check({tagname, ".imemload"}, bus.imemload, ed);
    check({tagname, ".iREN"},     {31'h0, bus.iREN}, {31'h0, er});
    check({tagname, ".iaddr"},    bus.iaddr, ea);
  endtask

  task automatic pulse_reset();
    nRST = 1'b0;
    @(posedge CLK);
    #1;
    nRST = 1'b1;
  endtask

  task automatic drive(input logic ren, input logic [31:0] addr, input logic wt,
                       input logic [31:0] load);
    bus.imemREN = ren; bus.imemaddr = addr; bus.iwait = wt; bus.iload = load;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    drive(1'b0, 32'h0, 1'b1, 32'h0);
    #2;
    check_outs("reset", 1'b0, 32'h0, 1'b0, 32'h0);
    @(posedge CLK);
    #1;
    nRST = 1'b1;

    // cold miss on 0x40, three wait cycles
    push(0, 1, 32'h40,  1, 32'hDEADBEEF, 0, 32'h0,        0, 32'h0);
    push(0, 1, 32'h40,  1, 32'hDEADBEEF, 0, 32'h0,        1, 32'h40);
    push(0, 1, 32'h40,  1, 32'hDEADBEEF, 0, 32'h0,        1, 32'h40);
    push(0, 1, 32'h40,  1, 32'hDEADBEEF, 0, 32'h0,        1, 32'h40);
    push(0, 1, 32'h40,  0, 32'h8C010004, 0, 32'h0,        1, 32'h40);
    push(0, 1, 32'h40,  1, 32'hDEADBEEF, 1, 32'h8C010004, 0, 32'h40);
    push(0, 1, 32'h42,  1, 32'hDEADBEEF, 1, 32'h8C010004, 0, 32'h40);
    // idle request on uncached address, then 0x40 still hits
    push(0, 0, 32'h300, 1, 32'h0,        0, 32'h0,        0, 32'h40);
    push(0, 1, 32'h40,  1, 32'h0,        1, 32'h8C010004, 0, 32'h40);
    // address changes during fill of 0x100
    push(0, 1, 32'h100, 1, 32'h0,        0, 32'h0,        0, 32'h40);
    push(0, 1, 32'h200, 1, 32'h0,        0, 32'h0,        1, 32'h100);
    push(0, 1, 32'h200, 0, 32'h11111111, 0, 32'h0,        1, 32'h100);
    push(0, 1, 32'h200, 1, 32'h0,        0, 32'h0,        0, 32'h100);
    push(0, 1, 32'h100, 1, 32'h0,        0, 32'h0,        1, 32'h200);
    push(0, 1, 32'h100, 0, 32'h22222222, 0, 32'h0,        1, 32'h200);
    push(0, 1, 32'h100, 1, 32'h0,        1, 32'h11111111, 0, 32'h200);
    push(0, 1, 32'h200, 1, 32'h0,        1, 32'h22222222, 0, 32'h200);
    // LRU eviction from a clean cache
    push(1, 1, 32'h000, 1, 32'h0,        0, 32'h0,        0, 32'h0);
    push(0, 1, 32'h000, 0, 32'hA0A0A0A0, 0, 32'h0,        1, 32'h0);
    push(0, 1, 32'h020, 1, 32'h0,        0, 32'h0,        0, 32'h0);
    push(0, 1, 32'h020, 0, 32'hA1A1A1A1, 0, 32'h0,        1, 32'h20);
    push(0, 1, 32'h000, 1, 32'h0,        1, 32'hA0A0A0A0, 0, 32'h20);
    push(0, 1, 32'h040, 1, 32'h0,        0, 32'h0,        0, 32'h20);
    push(0, 1, 32'h040, 0, 32'hA2A2A2A2, 0, 32'h0,        1, 32'h40);
    push(0, 1, 32'h040, 1, 32'h0,        1, 32'hA2A2A2A2, 0, 32'h40);
    push(0, 1, 32'h000, 1, 32'h0,        1, 32'hA0A0A0A0, 0, 32'h40);
    push(0, 1, 32'h020, 1, 32'h0,        0, 32'h0,        0, 32'h40);
    push(0, 1, 32'h020, 1, 32'h0,        0, 32'h0,        1, 32'h20);

    foreach (vq[i]) begin
      if (vq[i].do_rst) pulse_reset();
      drive(vq[i].ren, vq[i].addr, vq[i].wt, vq[i].load);
      #3;
      check_outs($sformatf("vec%0d", i), vq[i].eh, vq[i].ed, vq[i].er, vq[i].ea);
      step();
    end

    // reset asserted mid-fill clears the array
    pulse_reset();
    drive(1'b1, 32'h40, 1'b0, 32'hCAFE0040);
    step();
    #2;
    check_outs("rst_fill40", 1'b0, 32'h0, 1'b1, 32'h40);
    step();
    #2;
    check_outs("rst_hit40", 1'b1, 32'hCAFE0040, 1'b0, 32'h40);
    drive(1'b1, 32'h80, 1'b1, 32'h0);
    step();
    #2;
    check_outs("rst_fill80", 1'b0, 32'h0, 1'b1, 32'h80);
    nRST = 1'b0;
    #1;
    check_outs("rst_abort", 1'b0, 32'h0, 1'b0, 32'h0);
    step();
    nRST = 1'b1;
    drive(1'b1, 32'h40, 1'b1, 32'h0);
    #2;
    check_outs("rst_miss40", 1'b0, 32'h0, 1'b0, 32'h0);
    step();
    #2;
    check_outs("rst_refill40", 1'b0, 32'h0, 1'b1, 32'h40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/icache.md
# icache

Two-way set-associative, read-only instruction cache between the pipelined datapath's fetch port and the memory controller's instruction port. It serves `imemaddr` lookups with a same-cycle combinational hit and stalls fetch via `ihit`. On a miss it runs a single-word fill from the memory controller and replaces the least-recently-used way.

## Interface
- `INDEX_W`, default 3: set index width. Sets = 2^INDEX_W. Tag width = 30 - INDEX_W.
- `CLK`  in  1  clock, rising edge.
- `nRST`  in  1  reset, asynchronous, active-low.
- `imemREN`  in  1  datapath fetch request.
- `imemaddr`  in  32  fetch byte address. Bits [1:0] are ignored.
- `ihit`  out  1  `imemload` is valid this cycle.
- `imemload`  out  32  instruction word.
- `iREN`  out  1  fill request to the memory controller.
- `iaddr`  out  32  fill word address, with [1:0] = 0.
- `iwait`  in  1  memory controller busy. The fill data is valid in the cycle where `iREN`=1 and `iwait`=0.
- `iload`  in  32  fill data.

## Operation
- **Address split:** tag = addr[31:2+INDEX_W], index = addr[1+INDEX_W:2].
- **Per-set storage:** two frames, each holding {valid, tag, data}, plus one `lru` bit. `lru` names the way to evict next.
- **States:** IDLE and FILL.
- **IDLE:**
  - If `imemREN`=1 and a way in the set is valid with a matching tag: `ihit`=1 and `imemload` = that way's data. On the clock edge, set `lru` to the other way.
  - If `imemREN`=1 and no way matches: `ihit`=0. Latch `{imemaddr[31:2],2'b00}` into `miss_addr`. Go to FILL.
  - If `imemREN`=0: `ihit`=0 and state is unchanged.
- **FILL:**
  - `iREN`=1 and `iaddr`=`miss_addr`. `ihit`=0.
  - When `iwait`=0, write `iload` into the victim frame at `miss_addr`'s index: set valid=1 and tag = `miss_addr`'s tag. Set `lru` to the other way. Return to IDLE.
- **Victim selection:** way0 if it is invalid; else way1 if it is invalid; else the way given by `lru`.
- **Address changes during FILL:** the fill still completes for `miss_addr`. IDLE then re-evaluates the current `imemaddr`.
- **`imemREN` drop during FILL:** the fill completes regardless. No aborts.
- **Outputs when not hitting:** `imemload` = 0 whenever `ihit`=0.
- **Outputs in IDLE:** `iREN`=0 and `iaddr`=`miss_addr`.
- **No write path and no coherence.** Invalidation happens only through reset.

## Timing
- **Reset value of every output:** `ihit`=0, `imemload`=0, `iREN`=0, `iaddr`=0.
- **State on reset:** state=IDLE, all valid bits=0, all `lru`=0, `miss_addr`=0. Reset asserted mid-FILL aborts immediately with the same result.
- **Hit latency:** 0 cycles. `ihit` is combinational from `imemaddr`, `imemREN` and the array state.
- **Miss sequence:**
  - Cycle N: miss detected in IDLE.
  - Cycles N+1 onward: FILL, with `iREN`=1.
  - Let M be the first FILL cycle with `iwait`=0. The frame is written at the end of M.
  - Cycle M+1: IDLE. `ihit`=1 if `imemaddr` is unchanged.
  - Minimum miss penalty is 2 cycles (`iwait`=0 at N+1).
- **Data validity:** `iload` is sampled only in the cycle with `iwait`=0. Values while `iwait`=1 are ignored.
- **`ihit` in FILL:** `ihit` is never asserted during FILL, even if `imemaddr` would hit in the other set.
- **Simultaneous hit and LRU update:** the hit returns the pre-edge data, and `lru` changes at the edge.

## Test plan
- **Cold miss:** after reset, `imemREN`=1, `imemaddr`=0x00000040. Memory holds `iwait`=1 for 3 cycles, then `iload`=0x8C010004.
  - Required: `ihit`=0 through the fill.
  - Required: `iREN`=1 with `iaddr`=0x40 until the `iwait`=0 cycle.
  - Required: next cycle `ihit`=1 and `imemload`=0x8C010004.
- **Hit after fill:** re-present 0x40 and 0x42.
  - Required: `ihit`=1 in the same cycle with data 0x8C010004 for both addresses.
  - Required: `iREN` stays 0.
- **LRU eviction:** with INDEX_W=3, fill 0x000, then 0x020 (same set), then hit 0x000, then miss 0x040.
  - Required: 0x040 replaces the way holding 0x020.
  - Required: a later 0x000 hits and 0x020 misses.
- **Idle request:** `imemREN`=0 with an uncached address.
  - Required: `ihit`=0, `iREN`=0, and no state change.
- **Address change mid-fill:** `imemaddr` switches from 0x100 to 0x200 while `iwait`=1.
  - Required: `iaddr` stays 0x100 and the frame for 0x100 is filled.
  - Required: IDLE then misses on 0x200 and starts a new fill.
- **Reset mid-fill:** assert `nRST`=0 during FILL.
  - Required: `iREN`=0 immediately.
  - Required: after release, the previously cached 0x40 misses.
